alu_sequencer: RTL and testbench

Front-end driver for the 16-bit project ALU: accepts operation requests (opcode, A, B) from a host over a valid/ready interface and buffers them in a 4-entry FIFO. It issues them one at a time to the ALU with an `Enable` pulse and waits a fixed ALU latency. It then captures the ALU result and carry flag and returns them to the host over a second valid/ready interface. It sits between the testbench/controller and the ALU, driving the ALU's `Enable`/`Data_A`/`Data_B`/`Opcode` inputs and consuming its `Results`/`CF` outputs.

---
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Host request/response and ALU drive/return bundle for alu_sequencer.
// slave modport is the sequencer's view; master is the host-plus-ALU environment.
// Signal names follow the block's pin list so waveforms map one-to-one.
interface alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_cf;
  logic [3:0]  out_opcode;
  logic        alu_enable;
  logic [15:0] alu_data_a;
  logic [15:0] alu_data_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_results;
  logic        alu_cf;

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready, alu_results, alu_cf,
    output in_ready, out_valid, out_result, out_cf, out_opcode,
           alu_enable, alu_data_a, alu_data_b, alu_opcode
  );

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready, alu_results, alu_cf,
    input  in_ready, out_valid, out_result, out_cf, out_opcode,
           alu_enable, alu_data_a, alu_data_b, alu_opcode
  );
endinterface

// File: rtl/alu_sequencer.sv
// Purpose: queue host ALU requests in a small FIFO, issue one at a time to the ALU, return result+carry.
// Latency: push edge to out_valid = ALU_LAT+2 cycles when idle; throughput one op per ALU_LAT+2 cycles.
// Backpressure: in_ready drops when the FIFO is full; a held result (out_valid && !out_ready) stalls issue.
module alu_sequencer #(
  parameter int ALU_LAT = 2,   // 1..15, WAIT cycles before capturing the ALU outputs
  parameter int DEPTH   = 4    // power of two
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  alu_sequencer_if.slave  bus,
  output logic            o_busy,
  output logic [7:0]      o_op_count
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
  localparam logic [3:0]  C_LAT  = 4'(ALU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  // FIFO entry: opcode in the top nibble, then operand A, then operand B
  logic [35:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  state_t        r_state;
  logic [3:0]    r_wait_cnt;
  logic          r_alu_enable;
  logic [15:0]   r_alu_data_a;
  logic [15:0]   r_alu_data_b;
  logic [3:0]    r_alu_opcode;
  logic          r_out_valid;
  logic [15:0]   r_out_result;
  logic          r_out_cf;
  logic [3:0]    r_out_opcode;
  logic [7:0]    r_op_count;

  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [35:0]   w_head;

  // in_ready depends only on the count register, so it never combinationally follows in_valid
  assign bus.in_ready = (r_count != C_FULL);
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = (r_state == S_ISSUE);
  assign w_nonempty   = (r_count != '0);
  assign w_head       = r_mem[r_rd_ptr];

  // Entry storage; contents are only observed through the count, so no reset is needed
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_opcode, bus.in_a, bus.in_b};
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue/wait/hold sequencer; ALU operands load on entry to ISSUE and hold until the next issue
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_alu_enable <= 1'b0;
      r_alu_data_a <= '0;
      r_alu_data_b <= '0;
      r_alu_opcode <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_cf     <= 1'b0;
      r_out_opcode <= '0;
      r_op_count   <= '0;
    end else begin
      r_alu_enable <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_nonempty) begin
            r_state      <= S_ISSUE;
            r_alu_enable <= 1'b1;
            {r_alu_opcode, r_alu_data_a, r_alu_data_b} <= w_head;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= C_LAT;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt == 4'd1) begin
            r_out_result <= bus.alu_results;
            r_out_cf     <= bus.alu_cf;
            r_out_opcode <= r_alu_opcode;
            r_out_valid  <= 1'b1;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_op_count  <= r_op_count + 8'd1;
            if (w_nonempty) begin
              r_state      <= S_ISSUE;
              r_alu_enable <= 1'b1;
              {r_alu_opcode, r_alu_data_a, r_alu_data_b} <= w_head;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_enable = r_alu_enable;
  assign bus.alu_data_a = r_alu_data_a;
  assign bus.alu_data_b = r_alu_data_b;
  assign bus.alu_opcode = r_alu_opcode;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_cf     = r_out_cf;
  assign bus.out_opcode = r_out_opcode;
  assign o_op_count     = r_op_count;
  assign o_busy         = (r_state != S_IDLE) || w_nonempty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed steps plus random traffic against an in-order queue model.
// A second instance with ALU_LAT=1 runs continuous traffic for op_count wrap and 3-cycle spacing.
// ALU stubs are combinational from the sequencer's operand registers.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst1_n;
  logic       busy, busy1;
  logic [7:0] op_count, op_count1;

  always #5 clk = ~clk;

  alu_sequencer_if bus ();
  alu_sequencer_if bus1 ();

  alu_sequencer #(.ALU_LAT(2), .DEPTH(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave), .o_busy(busy), .o_op_count(op_count)
  );

  alu_sequencer #(.ALU_LAT(1), .DEPTH(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .bus(bus1.slave), .o_busy(busy1), .o_op_count(op_count1)
  );

  // Stand-in ALU: {carry, result}
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    case (op)
      4'd1:    r = {1'b0, a} + {1'b0, b};
      4'd2:    r = {1'b0, a} - {1'b0, b};
      4'd3:    r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  assign {bus.alu_cf, bus.alu_results}   = alu_fn(bus.alu_opcode, bus.alu_data_a, bus.alu_data_b);
  assign {bus1.alu_cf, bus1.alu_results} = alu_fn(bus1.alu_opcode, bus1.alu_data_a, bus1.alu_data_b);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state for the main instance
  logic [35:0] exp_q[$];
  int          exp_cnt  = 0;
  int          n_out    = 0;
  int          n_en     = 0;
  logic        prev_en  = 1'b0;
  logic        held_vld = 1'b0;
  logic [20:0] held_val = '0;

  // Main instance monitor: single-cycle enable, stable held outputs, in-order results, op_count
  always @(negedge clk) begin
    logic [35:0] e;
    logic [16:0] r;
    if (rst_n === 1'b1) begin
      if (bus.alu_enable) begin
        n_en++;
        chk("enable_single_cycle", prev_en, 0);
      end
      prev_en = bus.alu_enable;
      if (bus.out_valid && held_vld)
        chk("out_stable", {bus.out_opcode, bus.out_cf, bus.out_result}, held_val);
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          r = alu_fn(e[35:32], e[31:16], e[15:0]);
          chk("sb_result", bus.out_result, r[15:0]);
          chk("sb_cf", bus.out_cf, r[16]);
          chk("sb_opcode", bus.out_opcode, e[35:32]);
        end
        chk("sb_op_count", op_count, exp_cnt);
        exp_cnt  = (exp_cnt + 1) % 256;
        n_out++;
        held_vld = 1'b0;
      end else begin
        held_vld = bus.out_valid;
        held_val = {bus.out_opcode, bus.out_cf, bus.out_result};
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_opcode, bus.in_a, bus.in_b});
    end
  end

  // ALU_LAT=1 instance monitor: order/values and handshake spacing
  logic [35:0] q1[$];
  int          n1       = 0;
  int          cyc      = 0;
  int          last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [35:0] e;
    logic [16:0] r;
    if (rst1_n === 1'b1) begin
      if (bus1.out_valid && bus1.out_ready) begin
        chk("l1_sb_nonempty", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          r = alu_fn(e[35:32], e[31:16], e[15:0]);
          chk("l1_result", {bus1.out_opcode, bus1.out_cf, bus1.out_result}, {e[35:32], r[16], r[15:0]});
        end
        if (n1 > 0) chk("l1_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        n1++;
      end
      if (bus1.in_valid && bus1.in_ready)
        q1.push_back({bus1.in_opcode, bus1.in_a, bus1.in_b});
    end
  end

  // Called just after a rising edge; returns just after the accepting edge with in_valid low
  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk) ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("push_accept", ok, 1);
  endtask

  task automatic wait_out(input string tag);
    for (int k = 0; k < 60 && bus.out_valid !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_out_valid"}, bus.out_valid, 1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic acc;
    logic done;
    logic seen_issue;
    int   base;

    rst_n = 1'b0;  rst1_n = 1'b0;
    bus.in_valid  = 1'b0; bus.in_opcode  = '0; bus.in_a  = '0; bus.in_b  = '0; bus.out_ready  = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_opcode = '0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_enable", bus.alu_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_data", {bus.alu_data_a, bus.alu_data_b, bus.alu_opcode}, 0);
    chk("rst_out_data", {bus.out_result, bus.out_cf, bus.out_opcode}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: 3 + 4, timing from the accepting edge E0
    bus.in_valid = 1'b1; bus.in_opcode = 4'd1; bus.in_a = 16'h0003; bus.in_b = 16'h0004;
    @(posedge clk); #1; bus.in_valid = 1'b0;                     // E0
    chk("single_busy", busy, 1);
    chk("single_en_before", bus.alu_enable, 0);
    @(posedge clk); #1;                                           // E1
    chk("single_en_pulse", bus.alu_enable, 1);
    chk("single_alu_ops", {bus.alu_opcode, bus.alu_data_a, bus.alu_data_b}, {4'd1, 16'h0003, 16'h0004});
    @(posedge clk); #1;                                           // E2
    chk("single_en_fall", bus.alu_enable, 0);
    @(posedge clk); #1;                                           // E3
    chk("single_valid_early", bus.out_valid, 0);
    @(posedge clk); #1;                                           // E4
    chk("single_valid_at4", bus.out_valid, 1);
    chk("single_result", bus.out_result, 16'h0007);
    chk("single_cf", bus.out_cf, 0);
    chk("single_opcode", bus.out_opcode, 4'd1);
    take();
    chk("single_valid_clr", bus.out_valid, 0);
    chk("single_op_count", op_count, 1);
    chk("single_idle", busy, 0);
    chk("single_en_count", n_en, 1);

    // Carry out of the adder
    push(4'd1, 16'hFFFF, 16'h0001);
    wait_out("ovf");
    chk("ovf_result", bus.out_result, 16'h0000);
    chk("ovf_cf", bus.out_cf, 1);
    take();

    // Backpressure: 5 accepted with out_ready low fills the FIFO behind the held op
    for (int i = 0; i < 5; i++)
      push(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    wait_out("bp");
    chk("bp_full_in_ready", bus.in_ready, 0);
    chk("bp_busy", busy, 1);
    base = n_out;
    bus.in_valid = 1'b1; bus.in_opcode = 4'd2; bus.in_a = 16'h1234; bus.in_b = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_sixth_held_off", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    done = 1'b0;
    seen_issue = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk) acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (bus.alu_enable && !seen_issue) begin
        seen_issue = 1'b1;
        chk("issue_at_full_in_ready", bus.in_ready, 0);
      end
      if (acc && bus.in_valid) begin
        bus.in_valid = 1'b0;
        chk("refill_back_to_full", bus.in_ready, 0);
      end
      done = !bus.in_valid && exp_q.size() == 0 && !busy;
    end
    bus.out_ready = 1'b0;
    chk("bp_drained", done, 1);
    chk("bp_returned", n_out - base, 6);

    // Random traffic with random host backpressure
    for (int k = 0; k < 400; k++) begin
      @(negedge clk) acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (!bus.in_valid || acc) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_opcode = 4'($urandom_range(0, 15));
        bus.in_a      = 16'($urandom);
        bus.in_b      = 16'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #1;
      done = exp_q.size() == 0 && !busy;
    end
    bus.out_ready = 1'b0;
    chk("rand_drained", done, 1);
    chk("rand_op_count", op_count, exp_cnt);

    // Asynchronous reset mid-WAIT with three entries queued
    for (int i = 0; i < 4; i++)
      push(4'd1, 16'(i), 16'h0010);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_in_wait", bus.out_valid, 0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt  = 0;
    held_vld = 1'b0;
    prev_en  = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_op_count", op_count, 0);
    chk("arst_alu_enable", bus.alu_enable, 0);
    @(negedge clk) rst_n = 1'b1;
    n_en = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_issue", n_en, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // ALU_LAT=1: continuous traffic, op_count wraps after 256
    rst1_n = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.in_opcode = 4'($urandom_range(0, 15));
    bus1.in_a      = 16'($urandom);
    bus1.in_b      = 16'($urandom);
    bus1.out_ready = 1'b1;
    for (int k = 0; k < 2000 && n1 < 257; k++) begin
      @(negedge clk) acc = bus1.in_valid && bus1.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        bus1.in_opcode = 4'($urandom_range(0, 15));
        bus1.in_a      = 16'($urandom);
        bus1.in_b      = 16'($urandom);
      end
    end
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    chk("wrap_ops_done", n1, 257);
    chk("wrap_op_count", op_count1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
